// File: rtl/stack_machine_ext.sv
// rtl/stack_machine_ext.sv - single-cycle signed stack machine with sticky error flag
module stack_machine_ext #(
    parameter int N  = 8,
    parameter int S  = 8,
    parameter int DW = $clog2(S + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [N-1:0] g_input,
    input  logic        [3:0]   e_input,
    input  logic                e_valid,
    output logic signed [N-1:0] o,
    output logic        [DW-1:0] depth,
    output logic                err
);

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_PUSH = 4'd4;
    localparam logic [3:0] OP_NEG  = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_DUP  = 4'd9;
    localparam logic [3:0] OP_SWAP = 4'd10;
    localparam logic [3:0] OP_DROP = 4'd11;
    localparam logic [3:0] OP_SHL  = 4'd12;
    localparam logic [3:0] OP_SRA  = 4'd13;
    localparam logic [3:0] OP_LT   = 4'd14;

    logic signed [N-1:0] stk     [S];
    logic signed [N-1:0] nxt_stk [S];
    logic        [DW-1:0] nxt_depth;
    logic                 nxt_err;
    logic signed [N-1:0] s0, s1, bin_res, un_res;
    logic                 have1, have2, full;

    assign s0    = stk[0];
    assign s1    = stk[1];
    assign have1 = (depth != '0);
    assign have2 = (depth >= DW'(2));
    assign full  = (depth == DW'(S));
    assign o     = stk[0];

    // Two-operand and one-operand results; all arithmetic wraps at N bits
    always_comb begin
        bin_res = '0;
        un_res  = s0;
        case (e_input)
            OP_ADD:  bin_res = s0 + s1;
            OP_SUB:  bin_res = s0 - s1;
            OP_MUL:  bin_res = s0 * s1;
            OP_AND:  bin_res = s0 & s1;
            OP_OR:   bin_res = s0 | s1;
            OP_XOR:  bin_res = s0 ^ s1;
            OP_LT:   bin_res = (s0 < s1) ? N'(1) : '0;
            OP_NEG:  un_res  = -s0;
            OP_SHL:  un_res  = s0 <<< 1;
            OP_SRA:  un_res  = s0 >>> 1;
            default: ;
        endcase
    end

    // Next stack/depth/err; underflowing ops only raise err, overflowing pushes still shift
    always_comb begin
        nxt_stk   = stk;
        nxt_depth = depth;
        nxt_err   = err;
        if (e_valid) begin
            case (e_input)
                OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_LT: begin
                    if (!have2) begin
                        nxt_err = 1'b1;
                    end else begin
                        nxt_stk[0] = bin_res;
                        for (int j = 1; j < S - 1; j++) nxt_stk[j] = stk[j+1];
                        nxt_stk[S-1] = '0;
                        nxt_depth    = depth - DW'(1);
                    end
                end
                OP_NEG, OP_SHL, OP_SRA: begin
                    if (!have1) nxt_err = 1'b1;
                    else        nxt_stk[0] = un_res;
                end
                OP_PUSH, OP_DUP: begin
                    if (e_input == OP_DUP && !have1) begin
                        nxt_err = 1'b1;
                    end else begin
                        for (int j = 1; j < S; j++) nxt_stk[j] = stk[j-1];
                        nxt_stk[0] = (e_input == OP_DUP) ? s0 : g_input;
                        if (full) nxt_err = 1'b1;
                        else      nxt_depth = depth + DW'(1);
                    end
                end
                OP_SWAP: begin
                    if (!have2) begin
                        nxt_err = 1'b1;
                    end else begin
                        nxt_stk[0] = s1;
                        nxt_stk[1] = s0;
                    end
                end
                OP_DROP: begin
                    if (!have1) begin
                        nxt_err = 1'b1;
                    end else begin
                        for (int j = 0; j < S - 1; j++) nxt_stk[j] = stk[j+1];
                        nxt_stk[S-1] = '0;
                        nxt_depth    = depth - DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers; reset wins over any operation in the same cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int j = 0; j < S; j++) stk[j] <= '0;
            depth <= '0;
            err   <= 1'b0;
        end else begin
            stk   <= nxt_stk;
            depth <= nxt_depth;
            err   <= nxt_err;
        end
    end

endmodule

// File: tb/tb_stack_machine_ext.sv
// tb/tb_stack_machine_ext.sv - scoreboard bench for stack_machine_ext against a queue model
module tb_stack_machine_ext;

    localparam int N  = 8;
    localparam int S  = 4;
    localparam int DW = $clog2(S + 1);

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic signed [N-1:0]  g_input = '0;
    logic        [3:0]    e_input = '0;
    logic                 e_valid = 1'b0;
    logic signed [N-1:0]  o;
    logic        [DW-1:0] depth;
    logic                 err;

    stack_machine_ext #(.N(N), .S(S), .DW(DW)) dut (
        .clk(clk), .rst(rst), .g_input(g_input), .e_input(e_input),
        .e_valid(e_valid), .o(o), .depth(depth), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    o;
        int    d;
        bit    e;
        string tag;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int m[$];
    bit merr = 1'b0;

    function automatic int wrap8(input int x);
        logic signed [7:0] t;
        t = x[7:0];
        return int'(t);
    endfunction

    // Reference: stack as a queue with the top at index 0
    task automatic model(input int op, input int val, input bit valid, input bit rstv);
        int a, b, r;
        if (!rstv) begin
            m.delete();
            merr = 1'b0;
            return;
        end
        if (!valid) return;
        case (op)
            1, 2, 3, 6, 7, 8, 14: begin
                if (m.size() < 2) merr = 1'b1;
                else begin
                    a = m.pop_front();
                    b = m.pop_front();
                    case (op)
                        1: r = a + b;
                        2: r = a - b;
                        3: r = a * b;
                        6: r = a & b;
                        7: r = a | b;
                        8: r = a ^ b;
                        default: r = (a < b) ? 1 : 0;
                    endcase
                    m.push_front(wrap8(r));
                end
            end
            5, 12, 13: begin
                if (m.size() == 0) merr = 1'b1;
                else begin
                    a = m[0];
                    if (op == 5)       m[0] = wrap8(-a);
                    else if (op == 12) m[0] = wrap8(a * 2);
                    else               m[0] = wrap8(a >>> 1);
                end
            end
            4, 9: begin
                if (op == 9 && m.size() == 0) merr = 1'b1;
                else begin
                    a = (op == 9) ? m[0] : val;
                    m.push_front(a);
                    if (m.size() > S) begin
                        void'(m.pop_back());
                        merr = 1'b1;
                    end
                end
            end
            10: begin
                if (m.size() < 2) merr = 1'b1;
                else begin
                    a = m[0];
                    m[0] = m[1];
                    m[1] = a;
                end
            end
            11: begin
                if (m.size() == 0) merr = 1'b1;
                else void'(m.pop_front());
            end
            default: ;
        endcase
    endtask

    // Drive one cycle of stimulus and queue what the DUT must show after the next edge
    task automatic step(input int op, input int val, input bit valid, input bit rstv,
                        input string tag, input bit chk = 1'b0,
                        input int co = 0, input int cd = 0, input bit ce = 1'b0);
        exp_t x;
        @(negedge clk);
        e_input = 4'(op);
        g_input = N'(val);
        e_valid = valid;
        rst     = rstv;
        model(op, val, valid, rstv);
        x.tag = tag;
        if (chk) begin
            x.o = co;
            x.d = cd;
            x.e = ce;
        end else begin
            x.o = (m.size() > 0) ? m[0] : 0;
            x.d = m.size();
            x.e = merr;
        end
        sbq.push_back(x);
    endtask

    task automatic do_reset();
        step(0, 0, 1'b0, 1'b0, "reset", 1'b1, 0, 0, 1'b0);
    endtask

    // Monitor: one observation per clock, compared against the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                n_cmp++;
                if (int'(o) != e.o || int'(depth) != e.d || err !== e.e) begin
                    n_bad++;
                    $display("FAIL %s: got o=%0d depth=%0d err=%0b, want o=%0d depth=%0d err=%0b",
                             e.tag, o, depth, err, e.o, e.d, e.e);
                end
            end
        end
    end

    initial begin
        #2000000;
        n_bad++;
        $display("FAIL timeout: simulation did not complete, want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        int op, val;
        bit v, r;

        do_reset();
        do_reset();

        step(4, 5, 1, 1, "push5");
        step(4, 3, 1, 1, "push3");
        step(2, 0, 1, 1, "sub", 1'b1, -2, 1, 1'b0);

        do_reset();
        step(4, 100, 1, 1, "push100");
        step(4, 3, 1, 1, "push3");
        step(3, 0, 1, 1, "mul", 1'b1, 44, 1, 1'b0);
        step(5, 0, 1, 1, "neg", 1'b1, -44, 1, 1'b0);

        do_reset();
        for (int i = 1; i <= 4; i++) step(4, i, 1, 1, "push_fill");
        step(4, 5, 1, 1, "push_overflow", 1'b1, 5, 4, 1'b1);
        step(11, 0, 1, 1, "drop1");
        step(11, 0, 1, 1, "drop2");
        step(11, 0, 1, 1, "drop3", 1'b1, 2, 1, 1'b1);

        do_reset();
        step(1, 0, 1, 1, "add_underflow", 1'b1, 0, 0, 1'b1);
        for (int i = 0; i < 10; i++) step((i % 2) ? 15 : 0, 9, i % 3 != 0, 1, "nop_sticky");
        step(0, 0, 1, 1, "err_sticky", 1'b1, 0, 0, 1'b1);
        do_reset();

        step(4, -3, 1, 1, "push_m3");
        step(4, 2, 1, 1, "push2");
        step(10, 0, 1, 1, "swap");
        step(14, 0, 1, 1, "lt");
        step(4, -128, 1, 1, "push_m128");
        step(5, 0, 1, 1, "neg_min", 1'b1, -128, 2, 1'b0);
        step(13, 0, 1, 1, "sra", 1'b1, -64, 2, 1'b0);

        do_reset();
        step(4, 7, 0, 1, "push_invalid", 1'b1, 0, 0, 1'b0);
        step(4, 7, 1, 0, "push_in_reset", 1'b1, 0, 0, 1'b0);
        step(4, 9, 1, 1, "first_after_reset", 1'b1, 9, 1, 1'b0);

        for (int i = 0; i < 800; i++) begin
            op  = ($urandom_range(0, 99) < 30) ? 4 : int'($urandom_range(0, 15));
            val = wrap8(int'($urandom_range(0, 255)));
            v   = ($urandom_range(0, 99) < 90);
            r   = ($urandom_range(0, 99) >= 3);
            step(op, val, v, r, "random");
        end

        repeat (3) @(negedge clk);
        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
